prd_bht: RTL



---
 rtl/prd_bht_pkg.sv | 35 +++
 rtl/prd_imm_dec.sv | 24 ++
 rtl/prd_bht.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/prd_bht_pkg.sv
// Shared constants, decode payload and counter helper for the prd_bht branch predictor.
package prd_bht_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    localparam logic [6:0] INST_TYPE_B  = 7'b1100011;
    localparam logic [6:0] INST_JAL     = 7'b1101111;

    localparam logic JUMP_ENABLE  = 1'b1;
    localparam logic JUMP_DISABLE = 1'b0;
    localparam logic RST_ENABLE   = 1'b1;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [1:0]             cnt_t;

    typedef struct packed {
        logic       is_b;
        logic       is_jal;
        inst_addr_t imm;
    } dec_t;

    // 2-bit saturating counter step toward the resolved outcome
    function automatic cnt_t cnt_next(input cnt_t cnt, input logic taken);
        cnt_t res;
        res = cnt;
        if (taken) begin
            if (cnt != 2'b11) res = cnt + 2'b01;
        end else begin
            if (cnt != 2'b00) res = cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/prd_imm_dec.sv
// Combinational decode of the IF instruction into branch/JAL flags and sign-extended offset.
module prd_imm_dec
    import prd_bht_pkg::*;
(
    input  logic [INST_W-1:0] inst_i,
    output dec_t              dec_o
);

    always_comb begin
        dec_o = '0;
        case (inst_i[6:0])
            INST_TYPE_B: begin
                dec_o.is_b = 1'b1;
                dec_o.imm  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            end
            INST_JAL: begin
                dec_o.is_jal = 1'b1;
                dec_o.imm    = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            end
            default: dec_o = '0;
        endcase
    end

endmodule

// File: rtl/prd_bht.sv
// Dynamic branch predictor: PC-indexed 2-bit counter table, always-taken JAL, EX-driven training.
// Optional statistics counters are enabled by defining PRD_STATS_EN.
module prd_bht
    import prd_bht_pkg::*;
#(
    parameter int unsigned IDX_W    = 6,
    parameter logic [1:0]  INIT_CNT = 2'b01
) (
    input  logic             clk,
    input  logic             rstn,
    input  inst_addr_t       if_instaddr_i,
    input  logic [INST_W-1:0] if_inst_i,
    input  logic             ex_br_valid_i,
    input  inst_addr_t       ex_instaddr_i,
    input  logic             ex_jump_en_i,
    input  logic             prd_fail_i,
    output logic             prd_jump_en_o,
    output inst_addr_t       prd_jump_base_o,
    output inst_addr_t       prd_jump_ofset_o,
    output logic             bht_ready_o
`ifdef PRD_STATS_EN
    ,
    output logic [31:0]      stat_br_cnt_o,
    output logic [31:0]      stat_fail_cnt_o
`endif
);

    localparam int unsigned DEPTH = 2**IDX_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDX_W-1:0] r_init_idx;
    logic [IDX_W-1:0] w_init_idx_nxt;
    logic             r_ready;
    logic             w_ready_nxt;

    cnt_t             r_table [DEPTH];

    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    cnt_t             w_wr_data;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    dec_t             w_dec;
    logic             w_unused;

    assign w_if_idx = if_instaddr_i[IDX_W+1:2];
    assign w_ex_idx = ex_instaddr_i[IDX_W+1:2];
    assign w_unused = ^{ex_instaddr_i[INST_ADDR_W-1:IDX_W+2], ex_instaddr_i[1:0]};

    prd_imm_dec u_dec (
        .inst_i (if_inst_i),
        .dec_o  (w_dec)
    );

    always_ff @(posedge clk) begin
        if (rstn == RST_ENABLE) begin
            r_state    <= ST_INIT;
            r_init_idx <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_idx <= w_init_idx_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    // Next state plus the single table write port (init sweep or training)
    always_comb begin
        w_state_nxt    = r_state;
        w_init_idx_nxt = r_init_idx;
        w_ready_nxt    = r_ready;
        w_wr_en        = 1'b0;
        w_wr_idx       = r_init_idx;
        w_wr_data      = INIT_CNT;
        case (r_state)
            ST_INIT: begin
                w_wr_en        = 1'b1;
                w_init_idx_nxt = r_init_idx + IDX_W'(1);
                if (&r_init_idx) begin
                    w_state_nxt = ST_RUN;
                    w_ready_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (ex_br_valid_i) begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = w_ex_idx;
                    w_wr_data = cnt_next(r_table[w_ex_idx], ex_jump_en_i);
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if ((rstn != RST_ENABLE) && w_wr_en) begin
            r_table[w_wr_idx] <= w_wr_data;
        end
    end

    // Zero-latency lookup; reads the pre-update counter on a same-index collision
    always_comb begin
        prd_jump_en_o    = JUMP_DISABLE;
        prd_jump_base_o  = '0;
        prd_jump_ofset_o = '0;
        if ((r_state == ST_RUN) && (w_dec.is_jal || (w_dec.is_b && r_table[w_if_idx][1]))) begin
            prd_jump_en_o    = JUMP_ENABLE;
            prd_jump_base_o  = if_instaddr_i;
            prd_jump_ofset_o = w_dec.imm;
        end
    end

    assign bht_ready_o = r_ready;

`ifdef PRD_STATS_EN
    logic [31:0] r_stat_br_cnt;
    logic [31:0] r_stat_fail_cnt;

    always_ff @(posedge clk) begin
        if (rstn == RST_ENABLE) begin
            r_stat_br_cnt   <= '0;
            r_stat_fail_cnt <= '0;
        end else if ((r_state == ST_RUN) && ex_br_valid_i) begin
            r_stat_br_cnt <= r_stat_br_cnt + 32'd1;
            if (prd_fail_i) r_stat_fail_cnt <= r_stat_fail_cnt + 32'd1;
        end
    end

    assign stat_br_cnt_o   = r_stat_br_cnt;
    assign stat_fail_cnt_o = r_stat_fail_cnt;
`else
    logic w_unused_fail;
    assign w_unused_fail = prd_fail_i;
`endif

endmodule
